// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
// Coprocessor-0 register file and exception/interrupt controller for the
// single-cycle MIPS core. It holds Status, Cause and EPC, synchronises the
// six external interrupt lines, and decides each cycle whether the current
// instruction is replaced by an exception (hasexp -> next PC 0x00000800).
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   present_pc      PC of the instruction executing this cycle
//   iscop0, iseret  COP0 instruction / eret qualifier
//   mtc0            mtc0 qualifier (with iscop0)
//   cp0_addr        CP0 register number (rd field)
//   cp0_wdata       mtc0 write data
//   syscall, ri     synchronous exception sources
//   irq[5:0]        asynchronous level-sensitive interrupt lines
//   cp0_rdata       mfc0 read data (combinational from cp0_addr)
//   cp0_pcout       EPC, consumed by the PC mux on eret
//   hasexp          take an exception this cycle
//   status          current Status register (debug view)

module cp0_exc_ctrl #(
  parameter logic [31:0] PRID        = 32'h00018000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] present_pc,
  input  logic        iscop0,
  input  logic        iseret,
  input  logic        mtc0,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        syscall,
  input  logic        ri,
  input  logic [5:0]  irq,
  output logic [31:0] cp0_rdata,
  output logic [31:0] cp0_pcout,
  output logic        hasexp,
  output logic [31:0] status
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [4:0] ADDR_PRID   = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;

  // The EXL bit is the FSM state itself: NORMAL means EXL=0, HANDLER EXL=1.
  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES*6-1:0] sync_chain;
  logic [5:0]               sync_out;

  logic [7:0]  im_q;
  logic        ie_q;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;

  logic        exl;
  logic        int_pend;
  logic        do_eret;
  logic        do_mtc0;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [4:0]  exc_sel;
  logic [5:0]  ip_base;
  logic [31:0] status_word;
  logic [31:0] cause_word;

  // Decode of the current instruction. Anything that raises an exception
  // is killed, so eret and mtc0 only act when hasexp is low. If eret and
  // mtc0 were ever both flagged, eret takes precedence.
  always_comb begin
    exl       = (state == HANDLER);
    sync_out  = sync_chain[SYNC_STAGES*6-1 -: 6];
    // IM[9:8] are software-interrupt masks: stored but never used here.
    int_pend  = ie_q & ~exl & (|(ip_q & im_q[7:2]));
    hasexp    = syscall | ri | int_pend;
    do_eret   = iscop0 & iseret & ~hasexp;
    do_mtc0   = iscop0 & mtc0 & ~iseret & ~hasexp;
    wr_status = do_mtc0 & (cp0_addr == ADDR_STATUS);
    wr_cause  = do_mtc0 & (cp0_addr == ADDR_CAUSE);
    wr_epc    = do_mtc0 & (cp0_addr == ADDR_EPC);
    exc_sel   = ri ? EXC_RI : (syscall ? EXC_SYS : EXC_INT);
    // mtc0 to Cause replaces IP, then the synchroniser ORs in on top so a
    // freshly arriving interrupt is never lost to a concurrent clear.
    ip_base   = wr_cause ? cp0_wdata[15:10] : ip_q;
  end

  // Next-state logic for the NORMAL/HANDLER machine. Exception entry beats
  // eret and mtc0; a direct mtc0 to Status may move EXL either way.
  always_comb begin
    state_next = state;
    if (hasexp) begin
      state_next = HANDLER;
    end else if (do_eret) begin
      state_next = NORMAL;
    end else if (wr_status) begin
      state_next = cp0_wdata[1] ? HANDLER : NORMAL;
    end
  end

  // State register; reset drops straight back to NORMAL even mid-handler.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Interrupt synchroniser: a plain shift chain of 6-bit words, newest
  // sample in the low word, oldest (the synchronised output) in the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= '0;
    end else if (SYNC_STAGES > 1) begin
      sync_chain <= {sync_chain[SYNC_STAGES*6-7:0], irq};
    end else begin
      sync_chain <= irq;
    end
  end

  // Status/Cause/EPC storage. Exception entry captures the faulting PC and
  // the cause code and discards any mtc0 of the killed instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      im_q       <= '0;
      ie_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      ip_q <= ip_base | sync_out;
      if (hasexp) begin
        epc_q      <= present_pc;
        exc_code_q <= exc_sel;
      end else if (wr_status) begin
        im_q <= cp0_wdata[15:8];
        ie_q <= cp0_wdata[0];
      end else if (wr_epc) begin
        epc_q <= cp0_wdata;
      end
    end
  end

  // Register read mux; unimplemented and unmapped bits read as zero.
  always_comb begin
    status_word = {16'h0000, im_q, 6'b000000, exl, ie_q};
    cause_word  = {16'h0000, ip_q, 3'b000, exc_code_q, 2'b00};
    cp0_rdata   = 32'h0000_0000;
    case (cp0_addr)
      ADDR_STATUS: cp0_rdata = status_word;
      ADDR_CAUSE:  cp0_rdata = cause_word;
      ADDR_EPC:    cp0_rdata = epc_q;
      ADDR_PRID:   cp0_rdata = PRID;
      default:     cp0_rdata = 32'h0000_0000;
    endcase
  end

  assign cp0_pcout = epc_q;
  assign status    = status_word;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl
// Scoreboard bench for cp0_exc_ctrl. Each issued cycle pushes the outputs
// predicted by a behavioural CP0 model; a negedge monitor pops and compares.
// Directed scenarios also compare against literal values.

module tb_cp0_exc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] present_pc;
  logic        iscop0;
  logic        iseret;
  logic        mtc0;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        syscall;
  logic        ri;
  logic [5:0]  irq;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_pcout;
  logic        hasexp;
  logic [31:0] status;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        hasexp;
    logic [31:0] pcout;
    logic [31:0] status;
  } exp_t;

  exp_t sb[$];

  // Behavioural model state
  logic [7:0]  m_im;
  logic        m_exl;
  logic        m_ie;
  logic [5:0]  m_ip;
  logic [4:0]  m_exc;
  logic [31:0] m_epc;
  logic [5:0]  m_hist[$];

  cp0_exc_ctrl #(.PRID(32'h00018000), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .present_pc (present_pc),
    .iscop0     (iscop0),
    .iseret     (iseret),
    .mtc0       (mtc0),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .syscall    (syscall),
    .ri         (ri),
    .irq        (irq),
    .cp0_rdata  (cp0_rdata),
    .cp0_pcout  (cp0_pcout),
    .hasexp     (hasexp),
    .status     (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    return (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return model_status();
      5'd13:   return (32'(m_ip) << 10) | (32'(m_exc) << 2);
      5'd14:   return m_epc;
      5'd15:   return 32'h00018000;
      default: return 32'h0;
    endcase
  endfunction

  // Drives one instruction cycle, records the predicted outputs and then
  // advances the model as the coming clock edge will.
  task automatic applyStimulus(input logic r, input logic [31:0] pc, input logic cop,
                               input logic er, input logic mt, input logic [4:0] a,
                               input logic [31:0] wd, input logic sc, input logic rin,
                               input logic [5:0] ir);
    exp_t e;
    logic pend;
    logic take;
    logic [5:0] set_bits;
    @(posedge clk);
    #2;
    rst = r; present_pc = pc; iscop0 = cop; iseret = er; mtc0 = mt;
    cp0_addr = a; cp0_wdata = wd; syscall = sc; ri = rin; irq = ir;

    pend = m_ie && !m_exl && ((m_ip & m_im[7:2]) != 6'd0);
    take = sc || rin || pend;
    e.rdata  = model_read(a);
    e.hasexp = take;
    e.pcout  = m_epc;
    e.status = model_status();
    sb.push_back(e);

    if (r) begin
      m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_ip = '0; m_exc = '0; m_epc = '0;
      m_hist.delete();
      m_hist.push_back(6'd0);
      m_hist.push_back(6'd0);
    end else begin
      set_bits = m_hist.pop_front();
      m_hist.push_back(ir);
      if (take) begin
        m_epc = pc;
        m_exl = 1'b1;
        m_exc = rin ? 5'd10 : (sc ? 5'd8 : 5'd0);
      end else if (cop && er) begin
        m_exl = 1'b0;
      end else if (cop && mt) begin
        if (a == 5'd12) begin
          m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0];
        end else if (a == 5'd13) begin
          m_ip = wd[15:10];
        end else if (a == 5'd14) begin
          m_epc = wd;
        end
      end
      m_ip = m_ip | set_bits;
    end
  endtask

  task automatic idle(input logic [4:0] a, input logic [5:0] ir);
    applyStimulus(1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, a, 32'h0, 1'b0, 1'b0, ir);
  endtask

  task automatic writeCp0(input logic [4:0] a, input logic [31:0] wd, input logic [5:0] ir);
    applyStimulus(1'b0, 32'h00000104, 1'b1, 1'b0, 1'b1, a, wd, 1'b0, 1'b0, ir);
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs, so each
  // queued prediction is consumed on the following falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("sb_rdata",  cp0_rdata,       e.rdata);
      checkOutput("sb_hasexp", 32'(hasexp),     32'(e.hasexp));
      checkOutput("sb_pcout",  cp0_pcout,       e.pcout);
      checkOutput("sb_status", status,          e.status);
    end
  end

  initial begin
    logic       r_rst, r_sc, r_ri, r_cop, r_er, r_mt;
    logic [4:0] r_addr;
    logic [31:0] r_wd;
    int kind;

    rst = 1'b1; present_pc = '0; iscop0 = 1'b0; iseret = 1'b0; mtc0 = 1'b0;
    cp0_addr = '0; cp0_wdata = '0; syscall = 1'b0; ri = 1'b0; irq = '0;
    m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_ip = '0; m_exc = '0; m_epc = '0;
    m_hist.push_back(6'd0);
    m_hist.push_back(6'd0);

    // Reset and read back the register map
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'd0);
    idle(5'd12, 6'd0); #1;
    checkOutput("rst_status_rd", cp0_rdata, 32'h0);
    checkOutput("rst_hasexp", 32'(hasexp), 32'h0);
    checkOutput("rst_pcout", cp0_pcout, 32'h0);
    idle(5'd13, 6'd0); #1; checkOutput("rst_cause_rd", cp0_rdata, 32'h0);
    idle(5'd14, 6'd0); #1; checkOutput("rst_epc_rd", cp0_rdata, 32'h0);
    idle(5'd15, 6'd0); #1; checkOutput("rst_prid_rd", cp0_rdata, 32'h00018000);

    // Syscall entry
    applyStimulus(1'b0, 32'h00003010, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 6'd0); #1;
    checkOutput("sys_hasexp", 32'(hasexp), 32'h1);
    idle(5'd14, 6'd0); #1;
    checkOutput("sys_epc", cp0_rdata, 32'h00003010);
    checkOutput("sys_exl", status & 32'h2, 32'h2);
    idle(5'd13, 6'd0); #1;
    checkOutput("sys_exccode", (cp0_rdata >> 2) & 32'h1f, 32'd8);

    // Interrupt latency with IM2 and IE enabled
    writeCp0(5'd13, 32'h00000020, 6'd0);
    writeCp0(5'd12, 32'h00000401, 6'd0);
    idle(5'd13, 6'd1);
    idle(5'd13, 6'd0); #1; checkOutput("irq_lat_k1", 32'(hasexp), 32'h0);
    idle(5'd13, 6'd0); #1; checkOutput("irq_lat_k2", 32'(hasexp), 32'h0);
    applyStimulus(1'b0, 32'h00003014, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0, 1'b0, 1'b0, 6'd0); #1;
    checkOutput("irq_hasexp", 32'(hasexp), 32'h1);
    checkOutput("irq_ip10", cp0_rdata & 32'h400, 32'h400);
    idle(5'd13, 6'd0); #1;
    checkOutput("irq_cause", cp0_rdata, 32'h00000400);

    // eret with an interrupt still pending
    applyStimulus(1'b0, 32'h00000200, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'd0); #1;
    checkOutput("eret_pcout", cp0_pcout, 32'h00003014);
    checkOutput("eret_hasexp", 32'(hasexp), 32'h0);
    idle(5'd12, 6'd0); #1;
    checkOutput("eret_exl_clr", cp0_rdata & 32'h2, 32'h0);
    checkOutput("eret_repend", 32'(hasexp), 32'h1);

    // Interrupt masked by IE=0
    writeCp0(5'd13, 32'h00000000, 6'd0);
    writeCp0(5'd12, 32'h00000400, 6'd0);
    idle(5'd13, 6'd1);
    idle(5'd13, 6'd0);
    idle(5'd13, 6'd0);
    idle(5'd13, 6'd0); #1;
    checkOutput("mask_hasexp", 32'(hasexp), 32'h0);
    checkOutput("mask_ip10", (cp0_rdata >> 10) & 32'h3f, 32'h1);

    // ri together with mtc0 to Status: the write is discarded
    applyStimulus(1'b0, 32'h00000300, 1'b1, 1'b0, 1'b1, 5'd12, 32'hffffffff, 1'b0, 1'b1, 6'd0); #1;
    checkOutput("ri_hasexp", 32'(hasexp), 32'h1);
    idle(5'd12, 6'd0); #1; checkOutput("ri_status", cp0_rdata, 32'h00000402);
    idle(5'd13, 6'd0); #1; checkOutput("ri_exccode", (cp0_rdata >> 2) & 32'h1f, 32'd10);

    // Synchroniser set beats a concurrent mtc0 clear of IP
    idle(5'd13, 6'd2);
    idle(5'd13, 6'd0);
    writeCp0(5'd13, 32'h00000028, 6'd0);
    idle(5'd13, 6'd0); #1;
    checkOutput("ip_set_wins", (cp0_rdata >> 10) & 32'h3f, 32'h2);

    // Reset mid-handler with interrupt samples in flight
    writeCp0(5'd14, 32'h00000040, 6'd0);
    idle(5'd14, 6'h3f); #1; checkOutput("mid_epc", cp0_rdata, 32'h00000040);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0, 1'b0, 1'b0, 6'd0);
    idle(5'd13, 6'd0); #1;
    checkOutput("mid_status", status, 32'h0);
    checkOutput("mid_pcout", cp0_pcout, 32'h0);
    idle(5'd13, 6'd0); #1; checkOutput("mid_ip_flush", cp0_rdata, 32'h0);
    idle(5'd13, 6'd0); #1; checkOutput("mid_ip_flush2", cp0_rdata, 32'h0);

    // Randomised traffic checked through the scoreboard
    for (int i = 0; i < 2000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_sc  = ($urandom_range(0, 15) == 0);
      r_ri  = ($urandom_range(0, 15) == 0);
      r_cop = ($urandom_range(0, 2) == 0);
      kind  = $urandom_range(0, 2);
      r_er  = r_cop && (kind == 0);
      r_mt  = r_cop && (kind == 1);
      r_addr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      r_wd  = $urandom;
      if (r_addr == 5'd12 && $urandom_range(0, 1) == 1) r_wd[1:0] = 2'b01;
      if (r_addr == 5'd13) r_wd[6:2] = m_exc;
      applyStimulus(r_rst, {$urandom, 2'b00} , r_cop, r_er, r_mt, r_addr, r_wd,
                    r_sc, r_ri, 6'($urandom & $urandom & $urandom));
    end

    @(posedge clk); #2;
    rst = 1'b0; iscop0 = 1'b0; syscall = 1'b0; ri = 1'b0; irq = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("sb_drain", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
